// File: rtl/casr_ctrl.sv
// casr_ctrl: sequencing controller for the 37-bit hybrid rule-90/150 CASR.
// It warms the CASR up after a start command, then steps it in decimated
// bursts and presents the low OUT_W bits of its state on a valid/ready
// handshake. It also routes entropy into the CASR perturbation input and
// forces a reseed whenever the CASR sits in the all-zero lock-up state.
// The CASR instance's active-low rst_n must be tied to ~rst at integration.
module casr_ctrl #(
  parameter int unsigned WARMUP = 64,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_ent_bit,
  input  logic             i_ent_valid,
  output logic             o_ent_ready,
  input  logic [36:0]      i_casr_state,
  output logic             o_casr_en,
  output logic             o_casr_ptb,
  output logic             o_casr_ptb_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [7:0]       o_zero_cnt
);

  localparam int unsigned CMAX = (WARMUP > DECIM) ? WARMUP : DECIM;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP - 1);
  localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN,
    S_EMIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          casr_zero;

  // State and step-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: stop wins over counter completion and over the handshake.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_nx = S_WARMUP;
          cnt_nx   = '0;
        end
      end
      S_WARMUP: begin
        if (i_stop) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == WARM_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == DECIM_LAST) begin
          state_nx = S_EMIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_EMIT: begin
        if (i_stop) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (i_ready) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output decode: purely from the registered state plus CASR/entropy inputs.
  always_comb begin
    casr_zero        = (i_casr_state == '0);
    o_casr_en        = (state == S_WARMUP) || (state == S_RUN);
    o_valid          = (state == S_EMIT);
    o_busy           = (state != S_IDLE);
    o_ent_ready      = o_casr_en;
    o_data           = o_valid ? i_casr_state[OUT_W-1:0] : '0;
    o_casr_ptb       = o_casr_en && (casr_zero || i_ent_bit);
    o_casr_ptb_valid = o_casr_en && (casr_zero || i_ent_valid);
  end

  // Saturating count of forced reseeds; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_zero_cnt <= '0;
    end else if (o_casr_en && casr_zero && (o_zero_cnt != '1)) begin
      o_zero_cnt <= o_zero_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_casr_ctrl.sv
// tb_casr_ctrl: directed bench for casr_ctrl with a stub CASR and a
// behavioural reference model checked on every falling edge.
module tb_casr_ctrl;

  localparam int W = 64;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop, i_ent_bit, i_ent_valid, i_ready;
  logic        o_ent_ready, o_casr_en, o_casr_ptb, o_casr_ptb_valid;
  logic [15:0] o_data;
  logic        o_valid, o_busy;
  logic [7:0]  o_zero_cnt;
  logic [36:0] casr_state;

  int total = 0;
  int bad   = 0;
  bit ent_en = 1'b0;
  bit stuck  = 1'b0;

  always #5 clk = ~clk;

  casr_ctrl #(.WARMUP(W), .DECIM(D), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_ent_bit(i_ent_bit), .i_ent_valid(i_ent_valid), .o_ent_ready(o_ent_ready),
    .i_casr_state(casr_state), .o_casr_en(o_casr_en), .o_casr_ptb(o_casr_ptb),
    .o_casr_ptb_valid(o_casr_ptb_valid), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_zero_cnt(o_zero_cnt)
  );

  // Stub CASR: resets to zero, a forced reseed from zero gives 37'h10_0000_0001,
  // otherwise a nonzero-preserving rotate with the perturbation xored into bit 0.
  always @(posedge clk or posedge rst) begin
    if (rst) casr_state <= '0;
    else if (stuck) casr_state <= '0;
    else if (o_casr_en) begin
      if (casr_state == '0)
        casr_state <= (o_casr_ptb_valid && o_casr_ptb) ? 37'h10_0000_0001 : '0;
      else
        casr_state <= {casr_state[35:0], casr_state[36] ^ casr_state[0]}
                      ^ {36'd0, o_casr_ptb_valid & o_casr_ptb};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: busy flag, remaining warmup/run steps, emit pending.
  bit m_busy, m_emit;
  int m_warm, m_run, m_zc, m_accepts;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_emit = 0; m_warm = 0; m_run = 0; m_zc = 0; m_accepts = 0;
    end else begin
      if (m_busy && !m_emit && casr_state == '0 && m_zc < 255) m_zc++;
      if (!m_busy) begin
        if (i_start && !i_stop) begin
          m_busy = 1; m_emit = 0; m_warm = W; m_run = D;
        end
      end else if (i_stop) begin
        m_busy = 0; m_emit = 0;
      end else if (m_emit) begin
        if (i_ready) begin
          m_emit = 0; m_run = D; m_accepts++;
        end
      end else if (m_warm > 0) begin
        m_warm--;
      end else begin
        m_run--;
        if (m_run == 0) m_emit = 1;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic e_en, e_v;
    e_en = m_busy && !m_emit;
    e_v  = m_busy && m_emit;
    check("en",       {63'd0, o_casr_en}, {63'd0, e_en});
    check("ent_ready", {63'd0, o_ent_ready}, {63'd0, e_en});
    check("valid",    {63'd0, o_valid}, {63'd0, e_v});
    check("busy",     {63'd0, o_busy}, {63'd0, m_busy});
    check("data",     {48'd0, o_data}, e_v ? {48'd0, casr_state[15:0]} : 64'd0);
    check("ptb",      {63'd0, o_casr_ptb},
          {63'd0, e_en && (casr_state == '0 || i_ent_bit)});
    check("ptb_valid", {63'd0, o_casr_ptb_valid},
          {63'd0, e_en && (casr_state == '0 || i_ent_valid)});
    check("zero_cnt", {56'd0, o_zero_cnt}, 64'(m_zc));
  end

  // Entropy source, changed just after each rising edge.
  initial begin
    i_ent_bit = 0; i_ent_valid = 0;
    forever begin
      @(posedge clk); #1;
      i_ent_bit   = ent_en ? 1'($urandom) : 1'b0;
      i_ent_valid = ent_en ? 1'($urandom) : 1'b0;
    end
  end

  // Pulse start before edge 0, then observe cycles 1..80.
  task automatic measure_start(output int en_cnt, output int first_v, output int second_v,
                               output logic en69, output logic ptb1, output logic ptbv1,
                               output logic [7:0] zc2, output logic [36:0] st2);
    logic prev_v = 0;
    en_cnt = 0; first_v = 0; second_v = 0; en69 = 1'bx;
    ptb1 = 1'bx; ptbv1 = 1'bx; zc2 = 'x; st2 = 'x;
    @(posedge clk); #1 i_start = 1;
    @(posedge clk); #1 i_start = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n <= 68 && o_casr_en) en_cnt++;
      if (n == 69) en69 = o_casr_en;
      if (n == 1) begin ptb1 = o_casr_ptb; ptbv1 = o_casr_ptb_valid; end
      if (n == 2) begin zc2 = o_zero_cnt; st2 = casr_state; end
      if (o_valid && !prev_v) begin
        if (first_v == 0) first_v = n;
        else if (second_v == 0) second_v = n;
      end
      prev_v = o_valid;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (o_valid) ok = 1;
    end
  endtask

  initial begin
    int en_cnt, fv, sv, acc0;
    logic en69, p1, pv1;
    logic [7:0] zc2;
    logic [36:0] st2;
    logic [15:0] d0;
    bit ok;

    rst = 1; i_start = 0; i_stop = 0; i_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en",    {63'd0, o_casr_en}, 64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_busy",  {63'd0, o_busy}, 64'd0);
    check("rst_data",  {48'd0, o_data}, 64'd0);
    check("rst_zc",    {56'd0, o_zero_cnt}, 64'd0);
    @(negedge clk) rst = 0;

    // Start latency, cadence and forced reseed from the all-zero state.
    measure_start(en_cnt, fv, sv, en69, p1, pv1, zc2, st2);
    check("warm_en_cycles", 64'(en_cnt), 64'd68);
    check("en_cycle69", {63'd0, en69}, 64'd0);
    check("first_valid_cycle", 64'(fv), 64'd69);
    check("second_valid_cycle", 64'(sv), 64'd74);
    check("reseed_ptb", {63'd0, p1}, 64'd1);
    check("reseed_ptbv", {63'd0, pv1}, 64'd1);
    check("reseed_zc", {56'd0, zc2}, 64'd1);
    check("reseed_state", {27'd0, st2}, 64'h10_0000_0001);
    ent_en = 1;

    // Backpressure: hold off for 10 EMIT cycles.
    @(posedge clk); #1 i_ready = 0;
    wait_valid(ok);
    check("bp_reach_valid", {63'd0, ok}, 64'd1);
    d0 = o_data;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", {63'd0, o_valid}, 64'd1);
      check("bp_data", {48'd0, o_data}, {48'd0, d0});
      check("bp_en", {63'd0, o_casr_en}, 64'd0);
    end
    @(posedge clk); #1 i_ready = 1;
    @(negedge clk);
    check("bp_hs_valid", {63'd0, o_valid}, 64'd1);
    @(negedge clk);
    check("bp_after_en", {63'd0, o_casr_en}, 64'd1);
    check("bp_after_valid", {63'd0, o_valid}, 64'd0);

    // Stop in the first EMIT cycle, with i_ready high: stop must win.
    wait_valid(ok);
    check("stop_reach_valid", {63'd0, ok}, 64'd1);
    acc0 = m_accepts;
    i_stop = 1;
    @(posedge clk); #1 i_stop = 0;
    @(negedge clk);
    check("stop_busy", {63'd0, o_busy}, 64'd0);
    check("stop_valid", {63'd0, o_valid}, 64'd0);
    check("stop_no_accept", 64'(m_accepts), 64'(acc0));
    measure_start(en_cnt, fv, sv, en69, p1, pv1, zc2, st2);
    check("restart_en_cycles", 64'(en_cnt), 64'd68);
    check("restart_first_valid", 64'(fv), 64'd69);

    // CASR stuck at zero: reseed counter saturates.
    stuck = 1;
    repeat (400) @(posedge clk);
    #1;
    check("zc_saturated", {56'd0, o_zero_cnt}, 64'd255);
    i_stop = 1;
    @(posedge clk); #1 i_stop = 0;
    i_start = 1; i_stop = 1;
    @(posedge clk); #1 i_start = 0; i_stop = 0;
    @(negedge clk);
    check("start_stop_idle", {63'd0, o_busy}, 64'd0);
    check("zc_kept", {56'd0, o_zero_cnt}, 64'd255);
    stuck = 0;

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1 i_start = 1;
    @(posedge clk); #1 i_start = 0;
    wait_valid(ok);
    check("rr_reach_valid", {63'd0, ok}, 64'd1);
    @(negedge clk);
    check("rr_in_run", {63'd0, o_casr_en}, 64'd1);
    #2 rst = 1;
    #1;
    check("rr_en", {63'd0, o_casr_en}, 64'd0);
    check("rr_ptbv", {63'd0, o_casr_ptb_valid}, 64'd0);
    check("rr_ptb", {63'd0, o_casr_ptb}, 64'd0);
    check("rr_ent_ready", {63'd0, o_ent_ready}, 64'd0);
    check("rr_busy", {63'd0, o_busy}, 64'd0);
    check("rr_valid", {63'd0, o_valid}, 64'd0);
    check("rr_data", {48'd0, o_data}, 64'd0);
    check("rr_zc", {56'd0, o_zero_cnt}, 64'd0);
    #1 rst = 0;
    repeat (5) @(negedge clk);
    check("rr_stays_idle", {63'd0, o_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
